// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int WN_DEFAULT = 16;
  localparam int WD_DEFAULT = 8;
  localparam int CW_DEFAULT = $clog2(WN_DEFAULT + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DONE_Z = 2'd2
  } state_t;

  function automatic int cnt_width(input int wn);
    return $clog2(wn + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int WD = WD_DEFAULT
) (
  input  logic [WD:0]   i_p,
  input  logic          i_bit,
  input  logic [WD-1:0] i_divisor,
  output logic [WD:0]   o_p,
  output logic          o_qbit
);

  logic [WD:0] w_shift;
  logic [WD:0] w_dvs;
  logic        w_ge;

  // The incoming remainder is always below the divisor, so the top bit never carries.
  assign w_shift = (i_p << 1) | {{WD{1'b0}}, i_bit};
  assign w_dvs   = {1'b0, i_divisor};
  assign w_ge    = (w_shift >= w_dvs);
  assign o_p     = w_ge ? (w_shift - w_dvs) : w_shift;
  assign o_qbit  = w_ge;

endmodule

// File: rtl/division_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
module division_seq
  import div_pkg::*;
#(
  parameter int WN = WN_DEFAULT,
  parameter int WD = WD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [WN-1:0] dividend,
  input  logic [WD-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [WN-1:0] q,
  output logic [WD-1:0] r,
  output logic          dz
);

  localparam int CW = cnt_width(WN);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [WD:0]   r_p;
  logic [WN-1:0] r_dvd;
  logic [WD-1:0] r_dvs;
  logic [WN-1:0] r_q;
  logic [WD-1:0] r_r;
  logic          r_dz;
  logic          r_done;
  logic [WD:0]   w_p_next;
  logic          w_qbit;
  logic          w_last;

  div_step #(.WD(WD)) u_step (
    .i_p       (r_p),
    .i_bit     (r_dvd[WN-1]),
    .i_divisor (r_dvs),
    .o_p       (w_p_next),
    .o_qbit    (w_qbit)
  );

  assign w_last = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = (divisor != '0) ? S_RUN : S_DONE_Z;
      S_RUN:    if (w_last) w_state_next = S_IDLE;
      S_DONE_Z: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // The dividend register doubles as the quotient register: each step shifts
  // the consumed dividend MSB out and the new quotient bit in at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_p    <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_dz   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd <= dividend;
            r_dvs <= divisor;
            r_p   <= '0;
            r_cnt <= CW'(WN);
          end
        end
        S_RUN: begin
          r_p   <= w_p_next;
          r_dvd <= {r_dvd[WN-2:0], w_qbit};
          r_cnt <= r_cnt - CW'(1);
          if (w_last) begin
            r_q    <= {r_dvd[WN-2:0], w_qbit};
            r_r    <= w_p_next[WD-1:0];
            r_dz   <= 1'b0;
            r_done <= 1'b1;
          end
        end
        S_DONE_Z: begin
          r_q    <= '1;
          r_r    <= r_dvd[WD-1:0];
          r_dz   <= 1'b1;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign q    = r_q;
  assign r    = r_r;
  assign dz   = r_dz;

endmodule

// File: tb/tb_division_seq.sv
// Randomized and directed checks of division_seq against plain integer division.
module tb_division_seq;

  localparam int WN = 16;
  localparam int WD = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WN-1:0] dividend;
  logic [WD-1:0] divisor;
  logic          busy;
  logic          done;
  logic [WN-1:0] q;
  logic [WD-1:0] r;
  logic          dz;

  int n_checks = 0;
  int n_pass   = 0;
  int prev_q   = 0;

  division_seq #(.WN(WN), .WD(WD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .dz       (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic issue(input int dvd, input int dvs);
    start    = 1'b1;
    dividend = WN'(dvd);
    divisor  = WD'(dvs);
  endtask

  // Follows one accepted operation from its start edge to its done pulse.
  task automatic await_op(input string tag, input int dvd, input int dvs,
                          input int inj_cyc, input bit chain,
                          input int ndvd, input int ndvs);
    int cyc, nbusy, exp_q, exp_r, exp_lat, exp_busy;
    bit got, exp_dz;
    if (dvs == 0) begin
      exp_q = (1 << WN) - 1; exp_r = dvd % (1 << WD); exp_dz = 1'b1;
      exp_lat = 2; exp_busy = 0;
    end else begin
      exp_q = dvd / dvs; exp_r = dvd % dvs; exp_dz = 1'b0;
      exp_lat = WN + 1; exp_busy = WN;
    end
    @(posedge clk);
    cyc = 0; nbusy = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0; dividend = WN'($urandom); divisor = WD'($urandom);
        check({tag, "/q_held_during"}, int'(q), prev_q);
      end
      if (inj_cyc != 0 && cyc == inj_cyc) begin
        start = 1'b1; dividend = WN'(50); divisor = WD'(5);
      end
      if (inj_cyc != 0 && cyc == inj_cyc + 1) start = 1'b0;
      if (done) got = 1'b1;
      else if (busy) nbusy++;
    end
    check({tag, "/done_seen"}, int'(got), 1);
    if (got) begin
      check({tag, "/latency"}, cyc, exp_lat);
      check({tag, "/busy_cycles"}, nbusy, exp_busy);
      check({tag, "/busy_at_done"}, int'(busy), 0);
      check({tag, "/q"}, int'(q), exp_q);
      check({tag, "/r"}, int'(r), exp_r);
      check({tag, "/dz"}, int'(dz), int'(exp_dz));
      $display("op %s: %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", tag, dvd, dvs, q, r, dz, cyc);
    end
    prev_q = exp_q;
    if (chain) begin
      issue(ndvd, ndvs);
    end else begin
      @(negedge clk);
      check({tag, "/done_cleared"}, int'(done), 0);
      check({tag, "/q_held_after"}, int'(q), exp_q);
    end
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset/busy", int'(busy), 0);
    check("reset/done", int'(done), 0);
    check("reset/q", int'(q), 0);
    check("reset/r", int'(r), 0);
    check("reset/dz", int'(dz), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1234, 7);   await_op("basic", 1234, 7, 0, 0, 0, 0);
    issue(65280, 255); await_op("b_255", 65280, 255, 0, 0, 0, 0);
    issue(65535, 1);  await_op("b_one", 65535, 1, 0, 0, 0, 0);
    issue(100, 200);  await_op("b_big", 100, 200, 0, 0, 0, 0);
    issue(500, 0);    await_op("dz", 500, 0, 0, 0, 0, 0);
    issue(500, 3);    await_op("after_dz", 500, 3, 0, 0, 0, 0);

    issue(1000, 9);   await_op("ignore", 1000, 9, 5, 0, 0, 0);
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore/extra_done", ndone, 0);

    issue(1000, 9);   await_op("chain_a", 1000, 9, 0, 1, 77, 4);
    await_op("chain_b", 77, 4, 0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      int a, b;
      a = int'($urandom_range(0, 65535));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      issue(a, b);
      await_op($sformatf("rnd%0d", i), a, b, 0, 0, 0, 0);
    end

    issue(1000, 9);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("rst_mid/busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid/busy", int'(busy), 0);
    check("rst_mid/done", int'(done), 0);
    check("rst_mid/q", int'(q), 0);
    check("rst_mid/r", int'(r), 0);
    check("rst_mid/dz", int'(dz), 0);
    $display("op rst_mid: reset asserted during run, outputs busy=%0d q=%0d r=%0d", busy, q, r);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    prev_q = 0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_mid/no_done", ndone, 0);
    issue(20, 3);     await_op("after_rst", 20, 3, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
